// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM states, default widths, bubble encoding
// and the IF/ID record consumed by the decode stage.
package pipe_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic                   valid;
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pc;
    logic [PC_W_DEF-1:0]    pc_plus;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response handshake between the fetch stage and imem.
interface fetch_imem_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               req;
  logic [PC_W-1:0]    addr;
  logic               ready;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold freezes all fields, otherwise load a fetched
// instruction or a bubble (bubble keeps the pc fields).
module if_id_reg
  import pipe_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               load,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [PC_W-1:0]    pc_plus_in,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    pc_plus_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    pc_plus_q, pc_plus_d;

  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    pc_plus_d = pc_plus_q;
    if (!hold) begin
      if (load) begin
        valid_d   = 1'b1;
        instr_d   = instr_in;
        pc_d      = pc_in;
        pc_plus_d = pc_plus_in;
      end else begin
        valid_d   = 1'b0;
        instr_d   = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pc_plus_q <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pc_plus_q <= pc_plus_d;
    end
  end

  assign valid_o   = valid_q;
  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pc_plus_o = pc_plus_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, variable-latency imem handshake and IF/ID register.
//
// state | meaning
// BOOT  | first cycle after reset, no request, IF/ID is a bubble
// RUN   | request outstanding at pc, results loaded into IF/ID
// DRAIN | redirect arrived mid-access; finish the old access, then jump to pending_pc
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter int                 PC_STEP   = 1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_id,
  input  logic [PC_W-1:0]    redirect_pc,
  fetch_imem_if.master       imem,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc_plus
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pending_pc_q, pending_pc_d;
  logic [PC_W-1:0] pc_next_seq;
  logic            ifid_hold;
  logic            ifid_load;

  assign pc_next_seq = pc_q + STEP;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    ifid_hold    = 1'b0;
    ifid_load    = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stall) begin
          ifid_hold = 1'b1;
        end else if (redirect_id) begin
          if (imem.ready) begin
            pc_d = redirect_pc;
          end else begin
            // pc must stay put until the outstanding access completes
            pending_pc_d = redirect_pc;
            state_d      = ST_DRAIN;
          end
        end else if (imem.ready) begin
          ifid_load = 1'b1;
          pc_d      = pc_next_seq;
        end
      end
      ST_DRAIN: begin
        ifid_hold = stall;
        if (redirect_id && !stall) begin
          pending_pc_d = redirect_pc;
        end
        if (imem.ready) begin
          pc_d    = pending_pc_d;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      pending_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  assign imem.req  = (state_q != ST_BOOT);
  assign imem.addr = pc_q;

  if_id_reg #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (ifid_hold),
    .load       (ifid_load),
    .instr_in   (imem.rdata),
    .pc_in      (pc_q),
    .pc_plus_in (pc_next_seq),
    .valid_o    (if_id_valid),
    .instr_o    (if_id_instr),
    .pc_o       (if_id_pc),
    .pc_plus_o  (if_id_pc_plus)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID records queued per step, checked after the edge.
module tb_fetch_stage;
  import pipe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_id;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus;

  int checks   = 0;
  int failures = 0;

  if_id_t exp_q[$];

  fetch_imem_if #(.PC_W(32), .INSTR_W(32)) imem ();

  // imem model: word at address a holds 0xA0 + a
  assign imem.rdata = 32'hA0 + imem.addr;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect_id   (redirect_id),
    .redirect_pc   (redirect_pc),
    .imem          (imem.master),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc_plus (if_id_pc_plus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag);
    if_id_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".valid"},   32'(if_id_valid), 32'(e.valid));
      check({tag, ".instr"},   if_id_instr,      e.instr);
      check({tag, ".pc"},      if_id_pc,         e.pc);
      check({tag, ".pc_plus"}, if_id_pc_plus,    e.pc_plus);
    end
  endtask

  // Called at a negedge: drive inputs, check request side, push the IF/ID
  // expected after the next rising edge, then compare it.
  task automatic step(input string tag, input logic st, input logic rd,
                      input logic [31:0] rpc, input logic rdy,
                      input logic exp_req, input logic [31:0] exp_addr,
                      input logic ev, input logic [31:0] ei,
                      input logic [31:0] ep, input logic [31:0] epp);
    stall       = st;
    redirect_id = rd;
    redirect_pc = rpc;
    imem.ready  = rdy;
    #1;
    check({tag, ".req"},  32'(imem.req), 32'(exp_req));
    check({tag, ".addr"}, imem.addr,     exp_addr);
    exp_q.push_back('{valid: ev, instr: ei, pc: ep, pc_plus: epp});
    @(posedge clk);
    #1;
    check_ifid(tag);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".req"},     32'(imem.req),    32'd0);
    check({tag, ".addr"},    imem.addr,        32'd0);
    check({tag, ".valid"},   32'(if_id_valid), 32'd0);
    check({tag, ".instr"},   if_id_instr,      32'd0);
    check({tag, ".pc"},      if_id_pc,         32'd0);
    check({tag, ".pc_plus"}, if_id_pc_plus,    32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect_id = 1'b0;
    redirect_pc = '0;
    imem.ready  = 1'b1;
    #2;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // boot, then sequential fetch with a ready imem
    step("boot",  0, 0, 0, 1, 0, 32'h0, 0, 32'h0,  32'h0, 32'h0);
    step("seq0",  0, 0, 0, 1, 1, 32'h0, 1, 32'hA0, 32'h0, 32'h1);
    step("seq1",  0, 0, 0, 1, 1, 32'h1, 1, 32'hA1, 32'h1, 32'h2);
    step("seq2",  0, 0, 0, 1, 1, 32'h2, 1, 32'hA2, 32'h2, 32'h3);
    step("seq3",  0, 0, 0, 1, 1, 32'h3, 1, 32'hA3, 32'h3, 32'h4);
    step("seq4",  0, 0, 0, 1, 1, 32'h4, 1, 32'hA4, 32'h4, 32'h5);

    // stall two cycles at pc 5
    step("stall0", 1, 0, 0, 1, 1, 32'h5, 1, 32'hA4, 32'h4, 32'h5);
    step("stall1", 1, 0, 0, 1, 1, 32'h5, 1, 32'hA4, 32'h4, 32'h5);
    step("unst5",  0, 0, 0, 1, 1, 32'h5, 1, 32'hA5, 32'h5, 32'h6);
    step("seq6",   0, 0, 0, 1, 1, 32'h6, 1, 32'hA6, 32'h6, 32'h7);

    // redirect with ready imem: one bubble
    step("redir7",  0, 1, 32'h40, 1, 1, 32'h7,  0, 32'h0,  32'h6,  32'h7);
    step("tgt40",   0, 0, 0,      1, 1, 32'h40, 1, 32'hE0, 32'h40, 32'h41);

    // redirect while imem busy: drain the old access
    step("drain0",  0, 1, 32'h80, 0, 1, 32'h41, 0, 32'h0,   32'h40, 32'h41);
    step("drain1",  0, 0, 0,      0, 1, 32'h41, 0, 32'h0,   32'h40, 32'h41);
    step("drain2",  0, 0, 0,      0, 1, 32'h41, 0, 32'h0,   32'h40, 32'h41);
    step("drain3",  0, 0, 0,      1, 1, 32'h41, 0, 32'h0,   32'h40, 32'h41);
    step("tgt80",   0, 0, 0,      1, 1, 32'h80, 1, 32'h120, 32'h80, 32'h81);

    // stall and redirect together: redirect ignored, then re-asserted
    step("stlred",  1, 1, 32'h100, 1, 1, 32'h81,  1, 32'h120, 32'h80,  32'h81);
    step("redre",   0, 1, 32'h100, 1, 1, 32'h81,  0, 32'h0,   32'h80,  32'h81);
    step("tgt100",  0, 0, 0,       1, 1, 32'h100, 1, 32'h1A0, 32'h100, 32'h101);

    // drain: last redirect wins, stalled redirect ignored, stall does not block completion
    step("dlw0",    0, 1, 32'h200, 0, 1, 32'h101, 0, 32'h0,   32'h100, 32'h101);
    step("dlw1",    0, 1, 32'h300, 0, 1, 32'h101, 0, 32'h0,   32'h100, 32'h101);
    step("dlw2",    1, 1, 32'h500, 1, 1, 32'h101, 0, 32'h0,   32'h100, 32'h101);
    step("tgt300",  0, 0, 0,       1, 1, 32'h300, 1, 32'h3A0, 32'h300, 32'h301);

    // pc wrap at all-ones
    step("wrapr",   0, 1, 32'hFFFF_FFFF, 1, 1, 32'h301,       0, 32'h0,  32'h300,       32'h301);
    step("wrapf",   0, 0, 0,             1, 1, 32'hFFFF_FFFF, 1, 32'h9F, 32'hFFFF_FFFF, 32'h0);
    step("wrap0",   0, 0, 0,             1, 1, 32'h0,         1, 32'hA0, 32'h0,         32'h1);

    // reset asserted mid-drain
    step("rdr0",    0, 1, 32'h40, 0, 1, 32'h1, 0, 32'h0, 32'h0, 32'h1);
    redirect_id = 1'b0;
    imem.ready  = 1'b1;
    rst_n       = 1'b0;
    #1;
    check_reset("rst_async");
    @(posedge clk);
    #1;
    check_reset("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    step("boot2",   0, 0, 0, 1, 0, 32'h0, 0, 32'h0,  32'h0, 32'h0);
    step("seq0b",   0, 0, 0, 1, 1, 32'h0, 1, 32'hA0, 32'h0, 32'h1);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
